// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time instruction loader.
package loader_pkg;

    localparam int INST_W = 20;

    localparam logic [1:0]        OP_HALT   = 2'b11;
    localparam logic [INST_W-1:0] HALT_INST = {OP_HALT, 18'h0};

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        BURST,
        RUN,
        DONE,
        ERROR
    } state_t;

endpackage

// File: rtl/inst_loader_byte_packer.sv
// Packs three big-endian stream bytes into one instruction word and flags a
// first byte whose upper nibble is not zero.
module inst_byte_packer
    import loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              word_valid,
    output logic [INST_W-1:0] word,
    output logic              bad_nibble
);

    logic [1:0] phase;
    logic [3:0] hi_nib;
    logic [7:0] mid_byte;

    // NOTE: registered state is always written with <=, so every flop samples
    // the pre-edge value of its neighbours regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase    <= 2'd0;
            hi_nib   <= 4'h0;
            mid_byte <= 8'h00;
        end else if (clear) begin
            phase <= 2'd0;
        end else if (byte_valid) begin
            unique case (phase)
                2'd0: begin
                    hi_nib <= byte_data[3:0];
                    phase  <= 2'd1;
                end
                2'd1: begin
                    mid_byte <= byte_data;
                    phase    <= 2'd2;
                end
                default: phase <= 2'd0;
            endcase
        end
    end

    // The third byte completes the word on the same edge it is accepted.
    assign word_valid = byte_valid && (phase == 2'd2);
    assign word       = {hi_nib, mid_byte, byte_data};
    assign bad_nibble = byte_valid && (phase == 2'd0) && (byte_data[7:4] != 4'h0);

endmodule

// File: rtl/inst_loader.sv
// Boot loader: collects a counted byte stream into a local program buffer,
// bursts it into the CPU instruction memory, then supervises the CPU run.
module inst_loader
    import loader_pkg::*;
#(
    parameter int DEPTH       = 32,
    parameter int RUN_TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              cpu_rst_n,
    output logic              inst_mem_read_write,
    output logic [INST_W-1:0] input_inst,
    input  logic              cpu_halted,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int AW = $clog2(DEPTH);
    localparam int IW = AW + 1;
    localparam int TW = (RUN_TIMEOUT > 0) ? $clog2(RUN_TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] T_LAST = (RUN_TIMEOUT > 0) ? TW'(RUN_TIMEOUT - 1) : '0;
    localparam logic [TW-1:0] T_SAT  = TW'(RUN_TIMEOUT);

    state_t            state;
    logic [IW-1:0]     count;
    logic [IW-1:0]     idx;
    logic [IW-1:0]     k;
    logic [TW-1:0]     run_cnt;
    logic [INST_W-1:0] inst_buf [DEPTH];

    logic              accept;
    logic              count_ok;
    logic              timeout_hit;
    logic              go_error;
    logic              word_valid;
    logic [INST_W-1:0] word;
    logic              bad_nibble;

    assign accept      = s_valid && s_ready;
    assign count_ok    = (s_data != 8'd0) && (s_data <= 8'(DEPTH));
    assign timeout_hit = (RUN_TIMEOUT != 0) && (run_cnt == T_LAST);

    inst_byte_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (state != COLLECT),
        .byte_valid (accept && (state == COLLECT)),
        .byte_data  (s_data),
        .word_valid (word_valid),
        .word       (word),
        .bad_nibble (bad_nibble)
    );

    // NOTE: the default assignment up front keeps this block purely
    // combinational; leaving go_error unassigned on any path infers a latch.
    always_comb begin
        go_error = 1'b0;
        unique case (state)
            IDLE, DONE: go_error = accept && !count_ok;
            COLLECT:    go_error = bad_nibble;
            RUN:        go_error = !cpu_halted && timeout_hit;
            default:    go_error = 1'b0;
        endcase
    end

    // NOTE: the program buffer is plain storage with no reset; its contents
    // are rewritten before use, so a reset here would only cost area.
    always_ff @(posedge clk) begin
        if (word_valid) begin
            inst_buf[idx[AW-1:0]] <= word;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state               <= IDLE;
            s_ready             <= 1'b1;
            cpu_rst_n           <= 1'b0;
            inst_mem_read_write <= 1'b1;
            input_inst          <= '0;
            busy                <= 1'b0;
            done                <= 1'b0;
            err                 <= 1'b0;
            count               <= '0;
            idx                 <= '0;
            k                   <= '0;
            run_cnt             <= '0;
        end else if (go_error) begin
            state               <= ERROR;
            err                 <= 1'b1;
            s_ready             <= 1'b0;
            cpu_rst_n           <= 1'b0;
            inst_mem_read_write <= 1'b1;
            input_inst          <= '0;
            busy                <= 1'b0;
            done                <= 1'b0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        done      <= 1'b0;
                        cpu_rst_n <= 1'b0;
                        busy      <= 1'b1;
                        count     <= s_data[IW-1:0];
                        idx       <= '0;
                        state     <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (word_valid) begin
                        idx <= idx + IW'(1);
                        if (idx + IW'(1) == count) begin
                            // A one-instruction program is still being written this edge.
                            input_inst          <= (idx == '0) ? word : inst_buf[0];
                            s_ready             <= 1'b0;
                            cpu_rst_n           <= 1'b1;
                            inst_mem_read_write <= 1'b0;
                            k                   <= IW'(1);
                            state               <= BURST;
                        end
                    end
                end
                BURST: begin
                    if (k == IW'(DEPTH)) begin
                        inst_mem_read_write <= 1'b1;
                        input_inst          <= '0;
                        run_cnt             <= '0;
                        state               <= RUN;
                    end else begin
                        input_inst <= (k < count) ? inst_buf[k[AW-1:0]] : HALT_INST;
                        k          <= k + IW'(1);
                    end
                end
                RUN: begin
                    if (cpu_halted) begin
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        s_ready <= 1'b1;
                        state   <= DONE;
                    end else if (run_cnt != T_SAT) begin
                        run_cnt <= run_cnt + TW'(1);
                    end
                end
                ERROR: state <= ERROR;
                default: state <= ERROR;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_loader.sv
// Directed bench for inst_loader: load/burst, halt handshake, illegal streams,
// full-depth load with stalls, run timeout and asynchronous reset mid-burst.
module tb_inst_loader;
    import loader_pkg::*;

    localparam int DEPTH = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic [7:0]        s_data;
    logic              s_valid;
    logic              s_ready;
    logic              cpu_rst_n;
    logic              inst_mem_read_write;
    logic [INST_W-1:0] input_inst;
    logic              cpu_halted;
    logic              busy;
    logic              done;
    logic              err;

    int n_vec = 0;
    int n_bad = 0;

    logic [INST_W-1:0] prog [DEPTH];

    inst_loader #(.DEPTH(DEPTH), .RUN_TIMEOUT(16)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .s_data              (s_data),
        .s_valid             (s_valid),
        .s_ready             (s_ready),
        .cpu_rst_n           (cpu_rst_n),
        .inst_mem_read_write (inst_mem_read_write),
        .input_inst          (input_inst),
        .cpu_halted          (cpu_halted),
        .busy                (busy),
        .done                (done),
        .err                 (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        check({tag, ".s_ready"},   32'(s_ready),             32'd1);
        check({tag, ".cpu_rst_n"}, 32'(cpu_rst_n),           32'd0);
        check({tag, ".mode"},      32'(inst_mem_read_write), 32'd1);
        check({tag, ".inst"},      32'(input_inst),          32'd0);
        check({tag, ".busy"},      32'(busy),                32'd0);
        check({tag, ".done"},      32'(done),                32'd0);
        check({tag, ".err"},       32'(err),                 32'd0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check_reset("reset");
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int n;
        int gap;
        n   = 0;
        gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
        repeat (gap) step();
        s_data  = b;
        s_valid = 1'b1;
        while (!s_ready && n < 40) begin
            step();
            n++;
        end
        if (n == 40) check("s_ready_wait", 32'(s_ready), 32'd1);
        step();
        s_valid = 1'b0;
    endtask

    task automatic send_inst(input logic [INST_W-1:0] w, input int max_gap);
        send_byte({4'h0, w[19:16]}, max_gap);
        send_byte(w[15:8], max_gap);
        send_byte(w[7:0], max_gap);
    endtask

    initial begin
        logic [31:0] r;
        rst        = 1'b0;
        s_valid    = 1'b0;
        s_data     = 8'h00;
        cpu_halted = 1'b0;
        #12;
        check_reset("por");
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Halt from the CPU is ignored while idle
        cpu_halted = 1'b1;
        step();
        cpu_halted = 1'b0;
        check("idle_halt.done", 32'(done), 32'd0);

        // Two-instruction program, padded with HALT
        send_byte(8'h02, 0);
        check("t1.busy", 32'(busy), 32'd1);
        send_inst(20'h41234, 0);
        check("t1.mode_collect", 32'(inst_mem_read_write), 32'd1);
        check("t1.cpu_rst_collect", 32'(cpu_rst_n), 32'd0);
        send_inst(20'h85678, 0);
        check("t1.cpu_rst_n", 32'(cpu_rst_n), 32'd1);
        check("t1.mode0", 32'(inst_mem_read_write), 32'd0);
        check("t1.s_ready", 32'(s_ready), 32'd0);
        check("t1.inst0", 32'(input_inst), 32'h41234);
        for (int i = 1; i < DEPTH; i++) begin
            step();
            check($sformatf("t1.inst%0d", i), 32'(input_inst),
                  (i == 1) ? 32'h85678 : 32'(HALT_INST));
            check($sformatf("t1.mode%0d", i), 32'(inst_mem_read_write), 32'd0);
        end
        step();
        check("t1.mode_run", 32'(inst_mem_read_write), 32'd1);
        check("t1.inst_run", 32'(input_inst), 32'd0);
        check("t1.busy_run", 32'(busy), 32'd1);

        // CPU halts 5 cycles into RUN
        repeat (4) step();
        check("t2.done_pre", 32'(done), 32'd0);
        cpu_halted = 1'b1;
        step();
        cpu_halted = 1'b0;
        check("t2.done", 32'(done), 32'd1);
        check("t2.busy", 32'(busy), 32'd0);
        check("t2.s_ready", 32'(s_ready), 32'd1);
        check("t2.cpu_rst_n", 32'(cpu_rst_n), 32'd1);
        check("t2.err", 32'(err), 32'd0);
        step();
        check("t2.done_held", 32'(done), 32'd1);
        send_byte(8'h01, 0);
        check("t2.done_clr", 32'(done), 32'd0);
        check("t2.cpu_rst_lo", 32'(cpu_rst_n), 32'd0);
        check("t2.busy_again", 32'(busy), 32'd1);

        // One-instruction program, then run timeout
        send_inst(20'hFFFFF, 0);
        check("t6.inst0", 32'(input_inst), 32'hFFFFF);
        check("t6.mode0", 32'(inst_mem_read_write), 32'd0);
        repeat (DEPTH - 1) step();
        check("t6.inst_last", 32'(input_inst), 32'(HALT_INST));
        check("t6.mode_last", 32'(inst_mem_read_write), 32'd0);
        step();
        check("t6.mode_run", 32'(inst_mem_read_write), 32'd1);
        repeat (15) step();
        check("t6.err_pre", 32'(err), 32'd0);
        step();
        check("t6.err", 32'(err), 32'd1);
        check("t6.cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        check("t6.s_ready", 32'(s_ready), 32'd0);
        check("t6.busy", 32'(busy), 32'd0);
        check("t6.mode", 32'(inst_mem_read_write), 32'd1);

        // Error is sticky against halt and stream activity
        cpu_halted = 1'b1;
        s_valid    = 1'b1;
        s_data     = 8'h01;
        repeat (3) step();
        cpu_halted = 1'b0;
        s_valid    = 1'b0;
        check("sticky.err", 32'(err), 32'd1);
        check("sticky.done", 32'(done), 32'd0);
        do_reset();

        // Illegal counts
        send_byte(8'h00, 0);
        check("t3.zero.err", 32'(err), 32'd1);
        check("t3.zero.s_ready", 32'(s_ready), 32'd0);
        check("t3.zero.cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        do_reset();
        send_byte(8'h21, 0);
        check("t3.big.err", 32'(err), 32'd1);
        check("t3.big.s_ready", 32'(s_ready), 32'd0);
        check("t3.big.busy", 32'(busy), 32'd0);
        do_reset();

        // Bad high nibble in the second instruction
        send_byte(8'h02, 0);
        send_inst(20'h41234, 0);
        send_byte(8'h14, 0);
        check("t4.err", 32'(err), 32'd1);
        check("t4.mode", 32'(inst_mem_read_write), 32'd1);
        repeat (3) step();
        check("t4.mode_later", 32'(inst_mem_read_write), 32'd1);
        check("t4.cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        do_reset();

        // Full-depth program with random stalls
        for (int i = 0; i < DEPTH; i++) begin
            r       = $urandom;
            prog[i] = r[INST_W-1:0];
        end
        send_byte(8'h20, 2);
        for (int i = 0; i < DEPTH - 1; i++) send_inst(prog[i], 2);
        check("t5.mode_collect", 32'(inst_mem_read_write), 32'd1);
        send_inst(prog[DEPTH-1], 2);
        check("t5.mode0", 32'(inst_mem_read_write), 32'd0);
        check("t5.inst0", 32'(input_inst), 32'(prog[0]));
        for (int i = 1; i < DEPTH; i++) begin
            step();
            check($sformatf("t5.inst%0d", i), 32'(input_inst), 32'(prog[i]));
        end
        step();
        check("t5.mode_run", 32'(inst_mem_read_write), 32'd1);
        do_reset();

        // Asynchronous reset in the middle of a burst
        send_byte(8'h01, 0);
        send_inst(20'h01234, 0);
        repeat (10) step();
        check("t6b.mode_burst", 32'(inst_mem_read_write), 32'd0);
        #2;
        rst = 1'b0;
        #1;
        check_reset("t6b.async");
        @(posedge clk);
        #1;
        rst = 1'b1;
        check("t6b.s_ready", 32'(s_ready), 32'd1);
        send_byte(8'h01, 0);
        check("t6b.busy", 32'(busy), 32'd1);
        check("t6b.err", 32'(err), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
